// File: rtl/panxi_ifetch.sv
// Instruction-fetch front end: req/gnt/rvalid bus transaction into a 1-entry output register for ID.
// Optional WAIT-state watchdog enabled by defining PANXI_IFETCH_TIMEOUT_EN.
`ifndef PANXI_DW
`define PANXI_DW 32
`endif

module panxi_ifetch #(
    parameter logic [`PANXI_DW-1:0] NOP_INST       = 'h00000013,
    parameter int unsigned          TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [`PANXI_DW-1:0] inst_addr_xi,
    input  logic                 jmp_en_xi,
    input  logic                 hold_id_xi,
    output logic                 ibus_req_xo,
    output logic [`PANXI_DW-1:0] ibus_addr_xo,
    input  logic                 ibus_gnt_xi,
    input  logic                 ibus_rvalid_xi,
    input  logic [`PANXI_DW-1:0] ibus_rdata_xi,
    output logic [`PANXI_DW-1:0] inst_xo,
    output logic [`PANXI_DW-1:0] inst_addr_xo,
    output logic                 inst_valid_xo,
    output logic                 hold_req_xo,
    output logic                 ibus_err_xo
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_PEND} state_t;

    state_t               state_q, state_d;
    logic                 drop_q, drop_d;
    logic                 inst_valid_q;
    logic [`PANXI_DW-1:0] inst_q, inst_addr_q;
    logic [`PANXI_DW-1:0] req_addr_q, pend_data_q;
    logic                 slot_free, rsp_drop, load_rsp, load_pend, timeout;

    assign slot_free = !inst_valid_q || !hold_id_xi;
    assign rsp_drop  = drop_q || jmp_en_xi;
    assign load_rsp  = (state_q == S_WAIT) && ibus_rvalid_xi && !rsp_drop && slot_free;
    assign load_pend = (state_q == S_PEND) && slot_free && !jmp_en_xi;

`ifdef PANXI_IFETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       err_q;

    assign timeout = (state_q == S_WAIT) && !ibus_rvalid_xi && (tmo_cnt_q == TMO_LAST);

    // Counter idles at zero outside WAIT, so every entry into WAIT starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == S_WAIT) ? tmo_cnt_q + 8'd1 : 8'd0;
            err_q     <= timeout;
        end
    end

    assign ibus_err_xo = err_q;
`else
    assign timeout     = 1'b0;
    assign ibus_err_xo = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        drop_d  = drop_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (ibus_gnt_xi) begin
                    state_d = S_WAIT;
                    drop_d  = jmp_en_xi;
                end
            end
            S_WAIT: begin
                if (ibus_rvalid_xi) begin
                    drop_d  = 1'b0;
                    state_d = (rsp_drop || slot_free) ? S_REQ : S_PEND;
                end else if (timeout) begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end else if (jmp_en_xi) begin
                    drop_d = 1'b1;
                end
            end
            S_PEND: begin
                if (jmp_en_xi || slot_free) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_addr_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (jmp_en_xi)
                inst_valid_q <= 1'b0;
            else if (load_rsp || load_pend)
                inst_valid_q <= 1'b1;
            else if (inst_valid_q && !hold_id_xi)
                inst_valid_q <= 1'b0;
            if (load_rsp || load_pend) inst_addr_q <= req_addr_q;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed once a valid flag or state qualifies them.
    always_ff @(posedge clk) begin
        if (state_q == S_REQ && ibus_gnt_xi) req_addr_q <= inst_addr_xi;
        if (state_q == S_WAIT && ibus_rvalid_xi) pend_data_q <= ibus_rdata_xi;
        if (load_rsp)
            inst_q <= ibus_rdata_xi;
        else if (load_pend)
            inst_q <= pend_data_q;
    end

    assign ibus_req_xo   = !rst && (state_q == S_REQ);
    assign ibus_addr_xo  = inst_addr_xi;
    assign inst_xo       = inst_valid_q ? inst_q : NOP_INST;
    assign inst_addr_xo  = inst_addr_q;
    assign inst_valid_xo = inst_valid_q;
    assign hold_req_xo   = rst || !(load_rsp || load_pend);

endmodule

// File: tb/tb_panxi_ifetch.sv
// Directed bench for panxi_ifetch: bench-side PC generator, literal checks per scenario,
// and a per-cycle compare process enforcing the fetch/delivery rules.
`ifndef PANXI_DW
`define PANXI_DW 32
`endif

module tb_panxi_ifetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [`PANXI_DW-1:0] pc;
    logic [`PANXI_DW-1:0] jmp_target = '0;
    logic                 jmp_en_xi = 1'b0, hold_id_xi = 1'b0;
    logic                 ibus_gnt_xi = 1'b0, ibus_rvalid_xi = 1'b0;
    logic [`PANXI_DW-1:0] ibus_rdata_xi = '0;
    logic                 ibus_req_xo, inst_valid_xo, hold_req_xo, ibus_err_xo;
    logic [`PANXI_DW-1:0] ibus_addr_xo, inst_xo, inst_addr_xo;

    int vectors = 0;
    int miscompares = 0;

    panxi_ifetch dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr_xi   (pc),
        .jmp_en_xi      (jmp_en_xi),
        .hold_id_xi     (hold_id_xi),
        .ibus_req_xo    (ibus_req_xo),
        .ibus_addr_xo   (ibus_addr_xo),
        .ibus_gnt_xi    (ibus_gnt_xi),
        .ibus_rvalid_xi (ibus_rvalid_xi),
        .ibus_rdata_xi  (ibus_rdata_xi),
        .inst_xo        (inst_xo),
        .inst_addr_xo   (inst_addr_xo),
        .inst_valid_xo  (inst_valid_xo),
        .hold_req_xo    (hold_req_xo),
        .ibus_err_xo    (ibus_err_xo)
    );

    always #5 clk = ~clk;

    // PC generator: jump target loads at the next edge, otherwise +4 whenever the PC is not held.
    always @(posedge clk) begin
        if (rst)             pc <= '0;
        else if (jmp_en_xi)  pc <= jmp_target;
        else if (!hold_req_xo) pc <= pc + 32'd4;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rules checked every cycle: requested address is the PC, an idle output shows NOP, a jump
    // never coincides with a delivery and empties the output, a delivery presents the current PC
    // with the last bus response, and a stalled valid output survives unchanged.
    logic        p_deliver = 1'b0, p_keep = 1'b0, p_jmp = 1'b0;
    logic [31:0] p_pc, p_inst, p_addr, rsp_data;
    always @(negedge clk) begin
        if (rst) begin
            p_deliver = 1'b0;
            p_keep    = 1'b0;
            p_jmp     = 1'b0;
        end else begin
            if (p_deliver) begin
                check_bit("mdl_deliver_valid", inst_valid_xo, 1'b1);
                check("mdl_deliver_addr", inst_addr_xo, p_pc);
                check("mdl_deliver_data", inst_xo, rsp_data);
            end
            if (p_keep) begin
                check_bit("mdl_stall_valid", inst_valid_xo, 1'b1);
                check("mdl_stall_addr", inst_addr_xo, p_addr);
                check("mdl_stall_data", inst_xo, p_inst);
            end
            if (p_jmp) check_bit("mdl_jmp_clears_valid", inst_valid_xo, 1'b0);
            if (ibus_req_xo) check("mdl_req_addr", ibus_addr_xo, pc);
            if (!inst_valid_xo) check("mdl_nop_when_invalid", inst_xo, NOP);
            if (jmp_en_xi) check_bit("mdl_jmp_holds_pc", hold_req_xo, 1'b1);
            p_deliver = !hold_req_xo;
            p_pc      = pc;
            p_keep    = inst_valid_xo && hold_id_xi && !jmp_en_xi;
            p_addr    = inst_addr_xo;
            p_inst    = inst_xo;
            p_jmp     = jmp_en_xi;
            if (ibus_rvalid_xi) rsp_data = ibus_rdata_xi;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs just after the edge, then settle to sample before the next negedge.
    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic j, input logic [31:0] jt, input logic hid);
        cyc();
        ibus_gnt_xi    = g;
        ibus_rvalid_xi = rv;
        ibus_rdata_xi  = rd;
        jmp_en_xi      = j;
        jmp_target     = jt;
        hold_id_xi     = hid;
        #3;
    endtask

    initial begin
        repeat (2) cyc();
        #3;
        check_bit("rst_req", ibus_req_xo, 1'b0);
        check_bit("rst_valid", inst_valid_xo, 1'b0);
        check("rst_inst", inst_xo, NOP);
        check("rst_inst_addr", inst_addr_xo, 32'h0);
        check_bit("rst_hold", hold_req_xo, 1'b1);
        check_bit("rst_err", ibus_err_xo, 1'b0);

        cyc(); rst = 1'b0; #3;
        check_bit("idle_req", ibus_req_xo, 1'b0);
        check_bit("idle_hold", hold_req_xo, 1'b1);

        // Minimum-latency fetch at PC 0.
        drive(1, 0, 0, 0, 0, 0);
        check_bit("f0_req", ibus_req_xo, 1'b1);
        check("f0_addr", ibus_addr_xo, 32'h0);
        check_bit("f0_req_hold", hold_req_xo, 1'b1);
        drive(0, 1, 32'h00500093, 0, 0, 0);
        check_bit("f0_wait_req", ibus_req_xo, 1'b0);
        check_bit("f0_load_hold", hold_req_xo, 1'b0);
        drive(1, 0, 0, 0, 0, 0);
        check_bit("f0_valid", inst_valid_xo, 1'b1);
        check("f0_inst", inst_xo, 32'h00500093);
        check("f0_inst_addr", inst_addr_xo, 32'h0);
        check_bit("f0_after_hold", hold_req_xo, 1'b1);
        check("f1_addr", ibus_addr_xo, 32'h4);
        drive(0, 1, 32'h00400113, 0, 0, 0);
        check_bit("f1_load_hold", hold_req_xo, 1'b0);

        // Grant delayed by three cycles at PC 8.
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 0, 0, 0, 0, 0);
            check_bit("dly_req", ibus_req_xo, 1'b1);
            check("dly_addr", ibus_addr_xo, 32'h8);
            check_bit("dly_hold", hold_req_xo, 1'b1);
        end
        drive(0, 1, 32'h00600193, 0, 0, 0);
        check_bit("dly_load_hold", hold_req_xo, 1'b0);

        // Response arrives while ID stalls on a valid output: parked, then delivered.
        drive(1, 0, 0, 0, 0, 1);
        check("pend_prev_addr", inst_addr_xo, 32'h8);
        check("pend_req_addr", ibus_addr_xo, 32'hC);
        drive(0, 1, 32'hAABBCCDD, 0, 0, 1);
        check_bit("pend_rv_hold", hold_req_xo, 1'b1);
        drive(0, 0, 0, 0, 0, 1);
        check_bit("pend_stall_hold", hold_req_xo, 1'b1);
        check_bit("pend_stall_req", ibus_req_xo, 1'b0);
        check("pend_stall_addr", inst_addr_xo, 32'h8);
        drive(0, 0, 0, 0, 0, 0);
        check_bit("pend_release_hold", hold_req_xo, 1'b0);
        drive(1, 0, 0, 0, 0, 0);
        check("pend_inst", inst_xo, 32'hAABBCCDD);
        check("pend_inst_addr", inst_addr_xo, 32'hC);
        check("pend_next_addr", ibus_addr_xo, 32'h10);

        // Jump while waiting: the late response is discarded, refetch at the target.
        drive(0, 0, 0, 1, 32'h100, 0);
        check_bit("jw_hold", hold_req_xo, 1'b1);
        drive(0, 1, 32'hDEADBEEF, 0, 0, 0);
        check_bit("jw_drop_hold", hold_req_xo, 1'b1);
        check_bit("jw_valid", inst_valid_xo, 1'b0);
        drive(1, 0, 0, 0, 0, 0);
        check_bit("jw_after_valid", inst_valid_xo, 1'b0);
        check("jw_after_inst", inst_xo, NOP);
        check("jw_target_addr", ibus_addr_xo, 32'h100);
        drive(0, 1, 32'h00100213, 0, 0, 0);
        check_bit("jw_load_hold", hold_req_xo, 1'b0);

        // Jump in the grant cycle.
        drive(1, 0, 0, 1, 32'h200, 0);
        check("jg_inst_addr", inst_addr_xo, 32'h100);
        check("jg_req_addr", ibus_addr_xo, 32'h104);
        drive(0, 1, 32'h0BAD0001, 0, 0, 0);
        check_bit("jg_drop_hold", hold_req_xo, 1'b1);
        drive(1, 0, 0, 0, 0, 0);
        check("jg_target_addr", ibus_addr_xo, 32'h200);
        drive(0, 1, 32'h0000C200, 0, 0, 0);
        check_bit("jg_load_hold", hold_req_xo, 1'b0);

        // Jump in the rvalid cycle.
        drive(1, 0, 0, 0, 0, 0);
        check("jg_first_addr", inst_addr_xo, 32'h200);
        check("jg_first_inst", inst_xo, 32'h0000C200);
        drive(0, 1, 32'h0BAD0002, 1, 32'h300, 0);
        check_bit("jr_hold", hold_req_xo, 1'b1);
        drive(1, 0, 0, 0, 0, 0);
        check_bit("jr_valid", inst_valid_xo, 1'b0);
        check("jr_target_addr", ibus_addr_xo, 32'h300);
        drive(0, 1, 32'h0000C300, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("jr_first_addr", inst_addr_xo, 32'h300);
        check("jr_first_inst", inst_xo, 32'h0000C300);

        // Reset during WAIT; a late rvalid afterwards must be ignored.
        drive(1, 0, 0, 0, 0, 0);
        cyc(); ibus_gnt_xi = 1'b0; rst = 1'b1;
        cyc(); rst = 1'b0; ibus_rvalid_xi = 1'b1; ibus_rdata_xi = 32'h0BAD0003; #3;
        check_bit("rstw_hold", hold_req_xo, 1'b1);
        check_bit("rstw_req", ibus_req_xo, 1'b0);
        drive(0, 0, 0, 0, 0, 0);
        check_bit("rstw_valid", inst_valid_xo, 1'b0);
        check("rstw_req_addr", ibus_addr_xo, 32'h0);

`ifdef PANXI_IFETCH_TIMEOUT_EN
        begin
            int errs = 0;
            drive(1, 0, 0, 0, 0, 0);
            for (int i = 0; i < 300; i++) begin
                drive(0, 0, 0, 0, 0, 0);
                if (ibus_err_xo) begin
                    errs++;
                    check_bit("tmo_req", ibus_req_xo, 1'b1);
                    check("tmo_addr", ibus_addr_xo, 32'h0);
                    ibus_gnt_xi = 1'b0;
                end
            end
            check("tmo_err_pulses", errs, 32'd1);
        end
`endif

        drive(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/panxi_ifetch.md
Name: panxi_ifetch

Overview:
- Instruction-fetch front end on the consumer side of the PC interface.
- Takes `inst_addr_xi` from the PC generator and runs a req/gnt/rvalid transaction on the instruction bus.
- Presents the fetched instruction and its address to ID through a 1-entry output register.
- Raises `hold_req_xo`, which ctrl maps onto `HOLD_PC`, so the PC advances only when a fetch completes; a jump flushes any stale fetch in flight.

Parameters:
- `NOP_INST`, 32'h00000013, value driven on `inst_xo` whenever `inst_valid_xo`=0.
- `TIMEOUT_CYCLES`, 255, WAIT-state watchdog limit (used only with `PANXI_IFETCH_TIMEOUT_EN`); 8-bit counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `inst_addr_xi`  in  `PANXI_DW`  current PC.
- `jmp_en_xi`  in  1  jump taken this cycle; PC loads the jump address at the next edge.
- `hold_id_xi`  in  1  ID stalled; output register must not be consumed.
- `ibus_req_xo`  out  1  bus request.
- `ibus_addr_xo`  out  `PANXI_DW`  request address.
- `ibus_gnt_xi`  in  1  request accepted this cycle.
- `ibus_rvalid_xi`  in  1  read data valid; single-cycle pulse, cannot be back-pressured.
- `ibus_rdata_xi`  in  `PANXI_DW`  read data.
- `inst_xo`  out  `PANXI_DW`  instruction to ID.
- `inst_addr_xo`  out  `PANXI_DW`  address of `inst_xo`.
- `inst_valid_xo`  out  1  `inst_xo` valid.
- `hold_req_xo`  out  1  hold PC this cycle.
- `ibus_err_xo`  out  1  watchdog abort pulse (tied 0 when the feature is compiled out).

Behaviour:
- Reset: state=IDLE; `ibus_req_xo`=0; `inst_valid_xo`=0; `inst_xo`=`NOP_INST`; `inst_addr_xo`=0; `drop`=0; `hold_req_xo`=1; `ibus_err_xo`=0. Reset aborts any transaction in flight; a late rvalid after reset is ignored.
- `slot_free` = !`inst_valid_xo` | !`hold_id_xi`. When `inst_valid_xo`=1 and `hold_id_xi`=0, the output is consumed at that edge.
- IDLE: the next cycle always goes to REQ.
- REQ:
  - `ibus_req_xo`=1 and `ibus_addr_xo`=`inst_addr_xi` (combinational).
  - On `gnt`: latch `req_addr`, go to WAIT. Set `drop`=1 if `jmp_en_xi` is high the same cycle.
  - Without `gnt`: stay in REQ. The address may change after a jump; the bus tolerates address changes before grant.
- WAIT:
  - `ibus_req_xo`=0. `jmp_en_xi` sets `drop`.
  - On rvalid with `drop` or `jmp_en_xi` set: discard the data, clear `drop`, go to REQ.
  - On rvalid with `slot_free`: load `inst_xo`/`inst_addr_xo` from `rdata`/`req_addr`, set `inst_valid_xo`=1, go to REQ.
  - On rvalid without `slot_free`: capture into the pend register, go to PEND.
- PEND:
  - When `slot_free`: move pend into the output register, go to REQ.
  - `jmp_en_xi` discards pend and goes to REQ.
- `hold_req_xo`=0 only in the cycle an instruction is written to the output register (WAIT+rvalid+`slot_free`, or PEND+`slot_free`, in each case with no `drop`/jump). Otherwise it is 1, so the PC advances exactly once per delivered instruction.
- `jmp_en_xi` always clears `inst_valid_xo` at the next edge and wins over a simultaneous load.
- Minimum fetch latency (gnt immediate, rvalid the next cycle): REQ→WAIT→output valid, i.e. 1 instruction per 2 cycles.
- No address arithmetic in this block; PC+4 stays in the PC generator.

Optional Feature:
- `PANXI_IFETCH_TIMEOUT_EN` defined:
  - An 8-bit counter runs in WAIT and resets on entry to WAIT.
  - Reaching `TIMEOUT_CYCLES` without rvalid pulses `ibus_err_xo` for 1 cycle, clears `drop`, and returns to REQ, refetching the current `inst_addr_xi`.
  - A later stray rvalid while in REQ is ignored.
- Undefined: no counter, WAIT is held indefinitely, and `ibus_err_xo`=0.

Test Plan:
- Reset, then gnt immediate and rvalid 1 cycle later with `rdata`=32'h00500093 @ PC 0 -> `inst_valid_xo`=1, `inst_addr_xo`=0, `inst_xo`=32'h00500093; `hold_req_xo`=0 for exactly that cycle; next `ibus_addr_xo`=4.
- gnt delayed 3 cycles -> `ibus_req_xo` held 4 cycles, `ibus_addr_xo` stable at 8, `hold_req_xo`=1 throughout.
- `hold_id_xi`=1 with output valid when rvalid arrives (`rdata`=32'hAABBCCDD) -> PEND; after `hold_id_xi` drops, `inst_xo`=32'hAABBCCDD next cycle; no data lost.
- `jmp_en_xi` pulse in WAIT (jump to 32'h100), then rvalid -> data discarded, `inst_valid_xo`=0, next request address 32'h100.
- `jmp_en_xi` the same cycle as gnt -> response dropped; `jmp_en_xi` the same cycle as rvalid -> data dropped; in both cases the first delivered `inst_addr_xo` is the jump target.
- With `PANXI_IFETCH_TIMEOUT_EN`: gnt followed by no rvalid for 255 cycles -> `ibus_err_xo` pulses once and `ibus_req_xo` reasserts with the same address.
